// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the CPU data port, the image DMA engine and DataMemoryManager.
// The arbiter takes the slave side; the surrounding system drives the master side.
interface data_mem_arbiter_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_stall_o;
  logic        cpu_rvalid_o;
  logic        dma_req_i;
  logic        dma_we_i;
  logic [31:0] dma_addr_i;
  logic [31:0] dma_wdata_i;
  logic        dma_gnt_o;
  logic        dma_rvalid_o;
  logic        dma_err_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        mem_wren_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  mem_data_i,
    output cpu_stall_o, cpu_rvalid_o,
    output dma_gnt_o, dma_rvalid_o, dma_err_o,
    output rdata_o, mem_address_o, mem_data_o, mem_wren_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output mem_data_i,
    input  cpu_stall_o, cpu_rvalid_o,
    input  dma_gnt_o, dma_rvalid_o, dma_err_o,
    input  rdata_o, mem_address_o, mem_data_o, mem_wren_o
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// CPU/DMA arbiter for the single DataMemoryManager port: CPU priority by default,
// with a starvation guard that hands the DMA a bounded burst of grants.
module data_mem_arbiter #(
  parameter int          MAX_WAIT  = 8,
  parameter int          BURST_LEN = 4,
  parameter logic [31:0] DMA_BASE  = 32'd262144
) (
  input logic              CLK,
  input logic              RST,
  data_mem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [WW-1:0] L_MAX_WAIT  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] L_BURST_LEN = BW'(BURST_LEN);

  typedef enum logic {CPU_PRI = 1'b0, DMA_BURST = 1'b1} state_t;

  state_t        r_state, w_state_next;
  logic [WW-1:0] r_wait_cnt, w_wait_next;
  logic [BW-1:0] r_burst_cnt, w_burst_next;
  logic          r_cpu_rvalid, r_dma_rvalid;
  logic          w_cpu_win, w_dma_win, w_dma_err, w_dma_access;

  always_comb begin
    w_cpu_win = 1'b0;
    w_dma_win = 1'b0;
    if (!RST) begin
      if (r_state == DMA_BURST) begin
        w_dma_win = bus.dma_req_i;
        w_cpu_win = bus.cpu_req_i & ~bus.dma_req_i;
      end else begin
        w_cpu_win = bus.cpu_req_i;
        w_dma_win = bus.dma_req_i & ~bus.cpu_req_i;
      end
    end
    // An out-of-window DMA request is consumed without touching memory.
    w_dma_err    = w_dma_win & (bus.dma_addr_i < DMA_BASE);
    w_dma_access = w_dma_win & ~w_dma_err;
  end

  // The burst starts the cycle after the wait count saturates, so the DMA
  // starves exactly MAX_WAIT cycles under continuous CPU load.
  always_comb begin
    w_state_next = r_state;
    w_burst_next = r_burst_cnt;
    w_wait_next  = r_wait_cnt;
    if (w_dma_win)
      w_wait_next = '0;
    else if (bus.dma_req_i && r_wait_cnt != L_MAX_WAIT)
      w_wait_next = r_wait_cnt + 1'b1;
    case (r_state)
      CPU_PRI: begin
        if (bus.dma_req_i && !w_dma_win && w_wait_next == L_MAX_WAIT) begin
          w_state_next = DMA_BURST;
          w_burst_next = '0;
        end
      end
      DMA_BURST: begin
        if (w_dma_win)
          w_burst_next = r_burst_cnt + 1'b1;
        if (!bus.dma_req_i || w_burst_next == L_BURST_LEN)
          w_state_next = CPU_PRI;
      end
      default: w_state_next = CPU_PRI;
    endcase
  end

  always_comb begin
    bus.cpu_stall_o   = ~RST & bus.cpu_req_i & ~w_cpu_win;
    bus.dma_gnt_o     = w_dma_win;
    bus.dma_err_o     = w_dma_err;
    bus.mem_address_o = '0;
    bus.mem_data_o    = '0;
    bus.mem_wren_o    = 1'b0;
    if (w_cpu_win) begin
      bus.mem_address_o = bus.cpu_addr_i;
      bus.mem_data_o    = bus.cpu_wdata_i;
      bus.mem_wren_o    = bus.cpu_we_i;
    end else if (w_dma_access) begin
      bus.mem_address_o = bus.dma_addr_i;
      bus.mem_data_o    = bus.dma_wdata_i;
      bus.mem_wren_o    = bus.dma_we_i;
    end
    bus.cpu_rvalid_o = r_cpu_rvalid & ~RST;
    bus.dma_rvalid_o = r_dma_rvalid & ~RST;
    bus.rdata_o      = RST ? 32'h0 : bus.mem_data_i;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= CPU_PRI;
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_next;
      r_burst_cnt  <= w_burst_next;
      r_cpu_rvalid <= w_cpu_win & ~bus.cpu_we_i;
      r_dma_rvalid <= w_dma_access & ~bus.dma_we_i;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus random bench for data_mem_arbiter against a cycle-level
// priority/starvation model and a word-addressed memory model.
module tb_data_mem_arbiter;
  localparam int          MAX_WAIT  = 8;
  localparam int          BURST_LEN = 4;
  localparam logic [31:0] DMA_BASE  = 32'd262144;

  logic clk;
  logic RST;
  data_mem_arbiter_if bus ();

  data_mem_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .BURST_LEN(BURST_LEN),
    .DMA_BASE (DMA_BASE)
  ) dut (
    .CLK(clk),
    .RST(RST),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT: read data valid one clock after the address.
  logic [31:0] tb_mem [0:4095] = '{default: 32'h0};
  logic [31:0] r_mem_q;
  always @(posedge clk) begin
    if (bus.mem_wren_o)
      tb_mem[bus.mem_address_o[13:2]] <= bus.mem_data_o;
    r_mem_q <= tb_mem[bus.mem_address_o[13:2]];
  end
  assign bus.mem_data_i = r_mem_q;

  // Reference model state.
  logic [31:0] model_mem [0:4095] = '{default: 32'h0};
  int          m_wait;
  int          m_burst_left;
  bit          m_pend_cpu, m_pend_dma;
  logic [31:0] m_pend_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic        obs_stall, obs_gnt, obs_err, obs_wren, obs_cpu_rv, obs_dma_rv;
  logic [31:0] obs_rdata, obs_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit rst, input bit cr, input bit cw, input logic [31:0] ca,
                      input logic [31:0] cd, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dd);
    int          win;
    bit          pri, err;
    logic        e_stall, e_wren;
    logic [31:0] e_addr, e_data;
    @(negedge clk);
    RST             = rst;
    bus.cpu_req_i   = cr;
    bus.cpu_we_i    = cw;
    bus.cpu_addr_i  = ca;
    bus.cpu_wdata_i = cd;
    bus.dma_req_i   = dr;
    bus.dma_we_i    = dw;
    bus.dma_addr_i  = da;
    bus.dma_wdata_i = dd;
    #1;
    pri = (m_burst_left > 0);
    win = 0;
    if (!rst) begin
      if (cr && !(pri && dr)) win = 1;
      else if (dr)            win = 2;
    end
    err     = (win == 2) && (da < DMA_BASE);
    e_stall = !rst && cr && (win != 1);
    e_wren  = 1'b0;
    e_addr  = 32'h0;
    e_data  = 32'h0;
    if (win == 1) begin
      e_addr = ca; e_data = cd; e_wren = cw;
    end else if (win == 2 && !err) begin
      e_addr = da; e_data = dd; e_wren = dw;
    end
    obs_stall  = bus.cpu_stall_o;
    obs_gnt    = bus.dma_gnt_o;
    obs_err    = bus.dma_err_o;
    obs_wren   = bus.mem_wren_o;
    obs_addr   = bus.mem_address_o;
    obs_cpu_rv = bus.cpu_rvalid_o;
    obs_dma_rv = bus.dma_rvalid_o;
    obs_rdata  = bus.rdata_o;
    check("cpu_stall", {31'b0, obs_stall}, {31'b0, e_stall});
    check("dma_gnt", {31'b0, obs_gnt}, {31'b0, win == 2});
    check("dma_err", {31'b0, obs_err}, {31'b0, err});
    check("mem_wren", {31'b0, obs_wren}, {31'b0, e_wren});
    check("mem_address", obs_addr, e_addr);
    check("mem_data", bus.mem_data_o, e_data);
    check("cpu_rvalid", {31'b0, obs_cpu_rv}, {31'b0, !rst && m_pend_cpu});
    check("dma_rvalid", {31'b0, obs_dma_rv}, {31'b0, !rst && m_pend_dma});
    if (rst)
      check("rdata_rst", obs_rdata, 32'h0);
    else if (m_pend_cpu || m_pend_dma)
      check("rdata", obs_rdata, m_pend_data);

    if (rst) begin
      m_wait = 0; m_burst_left = 0; m_pend_cpu = 0; m_pend_dma = 0;
    end else begin
      m_pend_cpu = (win == 1) && !cw;
      m_pend_dma = (win == 2) && !err && !dw;
      if (win == 1) begin
        if (cw) model_mem[ca[13:2]] = cd;
        else    m_pend_data = model_mem[ca[13:2]];
      end else if (win == 2 && !err) begin
        if (dw) model_mem[da[13:2]] = dd;
        else    m_pend_data = model_mem[da[13:2]];
      end
      if (win == 2) begin
        m_wait = 0;
        if (pri) m_burst_left--;
      end else if (dr && m_wait < MAX_WAIT) begin
        m_wait++;
      end
      if (pri && !dr) m_burst_left = 0;
      if (!pri && dr && win != 2 && m_wait == MAX_WAIT) m_burst_left = BURST_LEN;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra, rd;
    bit          rdr, rcr;
    m_wait = 0; m_burst_left = 0; m_pend_cpu = 0; m_pend_dma = 0; m_pend_data = 32'h0;
    RST = 1'b1;
    bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = 0; bus.cpu_wdata_i = 0;
    bus.dma_req_i = 0; bus.dma_we_i = 0; bus.dma_addr_i = 0; bus.dma_wdata_i = 0;

    // Reset with both requesters active: every output is held at 0.
    step(1, 1, 1, 32'd100, 32'h1234, 1, 1, DMA_BASE, 32'h5678);
    step(1, 1, 0, 32'd100, 32'h0, 1, 0, DMA_BASE, 32'h0);
    check("reset_wren", {31'b0, obs_wren}, 32'h0);
    idle();

    // CPU write then read of address 100.
    step(0, 1, 1, 32'd100, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    check("cpu_wr_wren", {31'b0, obs_wren}, 32'h1);
    check("cpu_wr_stall", {31'b0, obs_stall}, 32'h0);
    step(0, 1, 0, 32'd100, 32'h0, 0, 0, 32'h0, 32'h0);
    idle();
    check("cpu_rd_rvalid", {31'b0, obs_cpu_rv}, 32'h1);
    check("cpu_rd_data", obs_rdata, 32'hDEADBEEF);

    // DMA-only write then read in the image window.
    step(0, 0, 0, 32'h0, 32'h0, 1, 1, DMA_BASE + 32'd8, 32'hCAFEF00D);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, DMA_BASE + 32'd8, 32'h0);
    check("dma_rd_gnt", {31'b0, obs_gnt}, 32'h1);
    idle();
    check("dma_rd_rvalid", {31'b0, obs_dma_rv}, 32'h1);
    check("dma_rd_cpu_rvalid", {31'b0, obs_cpu_rv}, 32'h0);
    check("dma_rd_data", obs_rdata, 32'hCAFEF00D);

    // Continuous contention: 8 starved cycles, 4 forced DMA grants, repeat.
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 0, 32'(i * 4), 32'h0, 1, 0, DMA_BASE + 32'(i * 4), 32'h0);
      check("starve_gnt", {31'b0, obs_gnt}, {31'b0, (i % 12) >= 8});
      check("starve_stall", {31'b0, obs_stall}, {31'b0, (i % 12) >= 8});
    end
    idle();

    // DMA write below the window is rejected.
    step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'd4000, 32'h11111111);
    check("err_gnt", {31'b0, obs_gnt}, 32'h1);
    check("err_pulse", {31'b0, obs_err}, 32'h1);
    check("err_wren", {31'b0, obs_wren}, 32'h0);
    idle();
    check("err_no_rvalid", {30'b0, obs_cpu_rv, obs_dma_rv}, 32'h0);
    check("err_pulse_gone", {31'b0, obs_err}, 32'h0);

    // Reset one cycle after a DMA read grant inside a burst.
    for (int i = 0; i < MAX_WAIT; i++)
      step(0, 1, 0, 32'd200, 32'h0, 1, 0, DMA_BASE + 32'd8, 32'h0);
    step(0, 1, 0, 32'd200, 32'h0, 1, 0, DMA_BASE + 32'd8, 32'h0);
    check("burst_gnt", {31'b0, obs_gnt}, 32'h1);
    step(1, 1, 0, 32'd200, 32'h0, 1, 0, DMA_BASE + 32'd8, 32'h0);
    check("rst_drop_rvalid", {31'b0, obs_dma_rv}, 32'h0);
    check("rst_rdata", obs_rdata, 32'h0);
    step(0, 1, 0, 32'd100, 32'h0, 1, 0, DMA_BASE + 32'd8, 32'h0);
    check("post_rst_cpu_wins", {30'b0, obs_stall, obs_gnt}, 32'h0);
    idle();
    check("post_rst_rdata", obs_rdata, 32'hDEADBEEF);

    // Random traffic against the model.
    rdr = 0; ra = DMA_BASE; rd = 32'h0;
    for (int i = 0; i < 300; i++) begin
      rcr = ($urandom_range(0, 2) != 0);
      if (!rdr && $urandom_range(0, 1) == 1) begin
        rdr = 1;
        ra  = ($urandom_range(0, 9) == 0) ? {18'b0, 2'b00, 10'($urandom_range(0, 1023)), 2'b00}
                                          : DMA_BASE + {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
        rd  = $urandom;
      end
      step(0, rcr, 1'($urandom_range(0, 1)), {20'b0, 10'($urandom_range(0, 1023)), 2'b00},
           $urandom, rdr, ra[3], ra, rd);
      if (obs_gnt) rdr = 0;
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
